// File: rtl/sram_track_ctrl_if.sv
// Control-side bundle of the track controller: record/play requests, settings and status.
// The master drives requests and settings; the slave (controller) drives acks, data and status.
interface sram_track_ctrl_if #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int NUM_TRACKS = 2,
  parameter int STEP_W     = 4
);
  localparam int LOG_NT = $clog2(NUM_TRACKS);
  localparam int TRK_W  = (LOG_NT < 1) ? 1 : LOG_NT;
  localparam int LW     = ADDR_W - LOG_NT;

  // Handshakes: i_rec_req / i_play_req are one-cycle strobes, honoured only
  // while the controller is idle. o_rec_ack and o_play_valid are one-cycle
  // completion pulses. There is no backpressure; requests arriving while busy
  // are dropped.
  logic              i_mode;
  logic [TRK_W-1:0]  i_track;
  logic              i_rec_req;
  logic [DATA_W-1:0] i_rec_data;
  logic              i_rec_clear;
  logic              i_play_req;
  logic              i_play_restart;
  logic [STEP_W-1:0] i_step;
  logic              i_reverse;
  logic              i_loop;
  logic              o_rec_ack;
  logic              o_play_valid;
  logic [DATA_W-1:0] o_play_data;
  logic              o_full;
  logic              o_play_done;
  logic [LW:0]       o_length;

  modport master (
    output i_mode, i_track, i_rec_req, i_rec_data, i_rec_clear,
           i_play_req, i_play_restart, i_step, i_reverse, i_loop,
    input  o_rec_ack, o_play_valid, o_play_data, o_full, o_play_done, o_length
  );

  modport slave (
    input  i_mode, i_track, i_rec_req, i_rec_data, i_rec_clear,
           i_play_req, i_play_restart, i_step, i_reverse, i_loop,
    output o_rec_ack, o_play_valid, o_play_data, o_full, o_play_done, o_length
  );
endinterface

// File: rtl/sram_track_ctrl.sv
// Multi-track record/playback controller for a 16-bit async SRAM.
// Each track owns an equal address region and its own recorded length.
module sram_track_ctrl #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int NUM_TRACKS = 2,
  parameter int STEP_W     = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  sram_track_ctrl_if.slave  ctl,
  output logic [ADDR_W-1:0] o_sram_addr,
  inout  wire  [DATA_W-1:0] io_sram_dq,
  output logic              o_sram_we_n,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n,
  output logic [1:0]        o_dbg_state
);
  localparam int LOG_NT = $clog2(NUM_TRACKS);
  localparam int TRK_W  = (LOG_NT < 1) ? 1 : LOG_NT;
  localparam int LW     = ADDR_W - LOG_NT;
  localparam int CW     = ((LW > STEP_W) ? LW : STEP_W) + 1;
  localparam logic [LW:0]   FULL_LEN = {1'b1, {LW{1'b0}}};
  localparam logic [LW-1:0] PTR_MAX  = {LW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  state_t            state;
  logic [LW-1:0]     ptr;
  logic [LW:0]       len_q [NUM_TRACKS];
  logic              done_q;
  logic              mode_q;
  logic [TRK_W-1:0]  trk_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_en_q;
  logic              zero_q;
  logic [CW-1:0]     step_q;
  logic              rev_q;
  logic              loop_q;
  logic              rec_ack_q;
  logic              play_valid_q;
  logic [DATA_W-1:0] play_data_q;
  logic [ADDR_W-1:0] addr_q;
  logic              ce_n_q;
  logic              we_n_q;
  logic              oe_n_q;
  logic              dq_oe_q;

  logic [TRK_W-1:0]  trk_in;
  logic [ADDR_W-1:0] acc_addr;
  logic [LW:0]       cur_len;
  logic              full;
  logic              ctx_change;
  logic [LW:0]       ptr_inc;
  logic [LW:0]       len_m1;
  logic [CW-1:0]     fwd_sum;
  logic [CW-1:0]     rev_diff;
  logic              fwd_over;
  logic              rev_under;

  // A single track has no track field in the address.
  if (LOG_NT == 0) begin : g_single
    assign trk_in   = '0;
    assign acc_addr = ptr;
  end else begin : g_multi
    assign trk_in   = ctl.i_track;
    assign acc_addr = {trk_q, ptr};
  end

  assign cur_len    = len_q[trk_q];
  assign full       = (cur_len == FULL_LEN);
  assign ctx_change = (ctl.i_mode != mode_q) || (trk_in != trk_q);
  assign ptr_inc    = {1'b0, ptr} + (LW+1)'(1);
  assign len_m1     = cur_len - (LW+1)'(1);
  assign fwd_sum    = CW'(ptr) + step_q;
  assign rev_diff   = CW'(ptr) - step_q;
  assign fwd_over   = (fwd_sum >= CW'(cur_len));
  assign rev_under  = (CW'(ptr) < step_q);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state        <= S_IDLE;
      ptr          <= '0;
      for (int t = 0; t < NUM_TRACKS; t++) len_q[t] <= '0;
      done_q       <= 1'b0;
      mode_q       <= 1'b0;
      trk_q        <= '0;
      wdata_q      <= '0;
      wr_en_q      <= 1'b0;
      zero_q       <= 1'b0;
      step_q       <= CW'(1);
      rev_q        <= 1'b0;
      loop_q       <= 1'b0;
      rec_ack_q    <= 1'b0;
      play_valid_q <= 1'b0;
      play_data_q  <= '0;
      addr_q       <= '0;
      ce_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      dq_oe_q      <= 1'b0;
    end else begin
      rec_ack_q    <= 1'b0;
      play_valid_q <= 1'b0;
      if (ctl.i_mode && ctl.i_rec_clear) begin
        // Erase aborts whatever is in flight and wins over a same-cycle record.
        len_q[trk_q] <= '0;
        ptr          <= '0;
        state        <= S_IDLE;
        ce_n_q       <= 1'b1;
        we_n_q       <= 1'b1;
        oe_n_q       <= 1'b1;
        dq_oe_q      <= 1'b0;
      end else if (!ctl.i_mode && ctl.i_play_restart && state != S_WRITE) begin
        ptr     <= (ctl.i_reverse && cur_len != '0) ? len_m1[LW-1:0] : '0;
        done_q  <= 1'b0;
        state   <= S_IDLE;
        ce_n_q  <= 1'b1;
        oe_n_q  <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (ctx_change) begin
              mode_q <= ctl.i_mode;
              trk_q  <= trk_in;
              ptr    <= '0;
              done_q <= 1'b0;
            end else if (mode_q && ctl.i_rec_req) begin
              wdata_q <= ctl.i_rec_data;
              addr_q  <= acc_addr;
              wr_en_q <= !full;
              ce_n_q  <= 1'b0;
              we_n_q  <= full;
              dq_oe_q <= !full;
              state   <= S_WRITE;
            end else if (!mode_q && ctl.i_play_req) begin
              addr_q <= acc_addr;
              zero_q <= (cur_len == '0);
              ce_n_q <= (cur_len == '0);
              oe_n_q <= (cur_len == '0);
              step_q <= (ctl.i_step == '0) ? CW'(1) : CW'(ctl.i_step);
              rev_q  <= ctl.i_reverse;
              loop_q <= ctl.i_loop;
              state  <= S_READ;
            end
          end
          S_WRITE: begin
            ce_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            dq_oe_q   <= 1'b0;
            rec_ack_q <= 1'b1;
            state     <= S_IDLE;
            if (wr_en_q) begin
              // The last slot fills the track without moving the pointer past it.
              if (ptr == PTR_MAX) begin
                len_q[trk_q] <= FULL_LEN;
              end else begin
                ptr <= ptr_inc[LW-1:0];
                if (ptr_inc > cur_len) len_q[trk_q] <= ptr_inc;
              end
            end
          end
          S_READ: begin
            state <= S_LATCH;
          end
          S_LATCH: begin
            play_data_q  <= zero_q ? '0 : io_sram_dq;
            play_valid_q <= 1'b1;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            state        <= S_IDLE;
            if (zero_q) begin
              done_q <= 1'b1;
            end else if (!rev_q) begin
              if (fwd_over) begin
                if (loop_q) ptr <= '0;
                else        done_q <= 1'b1;
              end else begin
                ptr <= fwd_sum[LW-1:0];
              end
            end else begin
              if (rev_under) begin
                if (loop_q) ptr <= len_m1[LW-1:0];
                else        done_q <= 1'b1;
              end else begin
                ptr <= rev_diff[LW-1:0];
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign io_sram_dq       = dq_oe_q ? wdata_q : 'z;
  assign o_sram_addr      = addr_q;
  assign o_sram_we_n      = we_n_q;
  assign o_sram_ce_n      = ce_n_q;
  assign o_sram_oe_n      = oe_n_q;
  assign o_sram_lb_n      = 1'b0;
  assign o_sram_ub_n      = 1'b0;
  assign o_dbg_state      = state;

  assign ctl.o_rec_ack    = rec_ack_q;
  assign ctl.o_play_valid = play_valid_q;
  assign ctl.o_play_data  = play_data_q;
  assign ctl.o_full       = full;
  assign ctl.o_play_done  = done_q;
  assign ctl.o_length     = cur_len;
endmodule

// File: tb/tb_sram_track_ctrl.sv
// Directed bench for sram_track_ctrl on a small 16-word SRAM (2 tracks of 8 words).
module tb_sram_track_ctrl;
  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 16;
  localparam int NUM_TRACKS = 2;
  localparam int STEP_W     = 4;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_track_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W),
                       .NUM_TRACKS(NUM_TRACKS), .STEP_W(STEP_W)) bus ();

  wire  [DATA_W-1:0] sram_dq;
  logic [ADDR_W-1:0] sram_addr;
  logic              we_n, ce_n, oe_n, lb_n, ub_n;
  logic [1:0]        dbg_state;
  logic [DATA_W-1:0] mem [16];

  sram_track_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W),
                    .NUM_TRACKS(NUM_TRACKS), .STEP_W(STEP_W)) dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .ctl         (bus),
    .o_sram_addr (sram_addr),
    .io_sram_dq  (sram_dq),
    .o_sram_we_n (we_n),
    .o_sram_ce_n (ce_n),
    .o_sram_oe_n (oe_n),
    .o_sram_lb_n (lb_n),
    .o_sram_ub_n (ub_n),
    .o_dbg_state (dbg_state)
  );

  // SRAM model
  assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr] : 'z;
  always @(negedge clk) if (!ce_n && !we_n) mem[sram_addr] <= sram_dq;

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic do_rec(input logic [15:0] d, input logic [3:0] a, input logic exp_we);
    bus.i_rec_data = d;
    bus.i_rec_req  = 1'b1;
    tick();
    bus.i_rec_req  = 1'b0;
    check("rec_state", 32'(dbg_state), 32'd1);
    check("rec_we_n", 32'(we_n), exp_we ? 32'd0 : 32'd1);
    check("rec_addr", 32'(sram_addr), 32'(a));
    check("rec_ack_early", 32'(bus.o_rec_ack), 32'd0);
    if (exp_we) check("rec_dq", 32'(sram_dq), 32'(d));
    tick();
    check("rec_ack", 32'(bus.o_rec_ack), 32'd1);
    check("rec_we_n_after", 32'(we_n), 32'd1);
  endtask

  task automatic do_play(input logic [3:0] a, input logic [15:0] d, input logic done);
    bus.i_play_req = 1'b1;
    tick();
    bus.i_play_req = 1'b0;
    check("play_read_state", 32'(dbg_state), 32'd2);
    check("play_strobes", 32'({ce_n, oe_n}), 32'd0);
    check("play_addr", 32'(sram_addr), 32'(a));
    tick();
    check("play_latch_state", 32'(dbg_state), 32'd3);
    check("play_valid_early", 32'(bus.o_play_valid), 32'd0);
    exp_q.push_back(32'(d));
    tick();
    check("play_valid", 32'(bus.o_play_valid), 32'd1);
    check("play_data", 32'(bus.o_play_data), exp_q.pop_front());
    check("play_done", 32'(bus.o_play_done), 32'(done));
  endtask

  logic [3:0] rv_addr [4];
  int         vcnt;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    bus.i_mode = 1'b0; bus.i_track = '0; bus.i_rec_req = 1'b0; bus.i_rec_data = '0;
    bus.i_rec_clear = 1'b0; bus.i_play_req = 1'b0; bus.i_play_restart = 1'b0;
    bus.i_step = '0; bus.i_reverse = 1'b0; bus.i_loop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(bus.o_rec_ack), 32'd0);
    check("rst_valid", 32'(bus.o_play_valid), 32'd0);
    check("rst_data", 32'(bus.o_play_data), 32'd0);
    check("rst_full", 32'(bus.o_full), 32'd0);
    check("rst_done", 32'(bus.o_play_done), 32'd0);
    check("rst_length", 32'(bus.o_length), 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_strobes", 32'({ce_n, we_n, oe_n}), 32'h7);
    check("rst_lb_ub", 32'({lb_n, ub_n}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    tick();

    // record five samples on track 0
    bus.i_mode = 1'b1; bus.i_track = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) do_rec(16'hA000 + 16'(i), 4'(i), 1'b1);
    check("len_t0", 32'(bus.o_length), 32'd5);
    check("full_t0", 32'(bus.o_full), 32'd0);
    check("mem4", 32'(mem[4]), 32'hA004);

    // forward play, step 1, no loop
    bus.i_mode = 1'b0; bus.i_step = 4'd1;
    tick();
    for (int i = 0; i < 6; i++)
      do_play((i < 5) ? 4'(i) : 4'd4, (i < 5) ? 16'hA000 + 16'(i) : 16'hA004, (i >= 4));

    // reverse, step 2, loop, after restart
    bus.i_reverse = 1'b1; bus.i_step = 4'd2; bus.i_loop = 1'b1; bus.i_play_restart = 1'b1;
    tick();
    bus.i_play_restart = 1'b0;
    check("restart_done", 32'(bus.o_play_done), 32'd0);
    rv_addr[0] = 4'd4; rv_addr[1] = 4'd2; rv_addr[2] = 4'd0; rv_addr[3] = 4'd4;
    for (int i = 0; i < 4; i++) do_play(rv_addr[i], 16'hA000 + 16'(rv_addr[i]), 1'b0);

    // fill track 1, then one more record that must not write
    bus.i_mode = 1'b1; bus.i_track = 1'b1; bus.i_reverse = 1'b0; bus.i_loop = 1'b0; bus.i_step = 4'd1;
    tick();
    for (int i = 0; i < 8; i++) begin
      do_rec(16'hB000 + 16'(i), 4'(8 + i), 1'b1);
      check("full_flag", 32'(bus.o_full), (i == 7) ? 32'd1 : 32'd0);
    end
    check("len_t1", 32'(bus.o_length), 32'd8);
    do_rec(16'hB008, 4'hF, 1'b0);
    check("mem15_kept", 32'(mem[15]), 32'hB007);
    check("len_t1_hold", 32'(bus.o_length), 32'd8);
    bus.i_track = 1'b0;
    tick();
    check("len_t0_kept", 32'(bus.o_length), 32'd5);
    check("full_t0_again", 32'(bus.o_full), 32'd0);

    // clear wins over a same-cycle record
    bus.i_rec_req = 1'b1; bus.i_rec_clear = 1'b1; bus.i_rec_data = 16'hC000;
    tick();
    bus.i_rec_req = 1'b0; bus.i_rec_clear = 1'b0;
    check("clr_we_n", 32'(we_n), 32'd1);
    check("clr_state", 32'(dbg_state), 32'd0);
    check("clr_len", 32'(bus.o_length), 32'd0);
    check("clr_ack1", 32'(bus.o_rec_ack), 32'd0);
    tick();
    check("clr_ack2", 32'(bus.o_rec_ack), 32'd0);
    check("clr_mem0", 32'(mem[0]), 32'hA000);

    // play request repeated during READ is dropped
    bus.i_mode = 1'b0; bus.i_track = 1'b1;
    tick();
    bus.i_play_req = 1'b1;
    tick();
    check("drop_read_state", 32'(dbg_state), 32'd2);
    tick();
    bus.i_play_req = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.o_play_valid) begin
        vcnt++;
        check("drop_data", 32'(bus.o_play_data), 32'hB000);
      end
    end
    check("drop_valid_cnt", 32'(vcnt), 32'd1);

    // asynchronous reset in the middle of a write
    bus.i_mode = 1'b1; bus.i_track = 1'b0;
    tick();
    bus.i_rec_data = 16'hD000; bus.i_rec_req = 1'b1;
    tick();
    bus.i_rec_req = 1'b0;
    check("mid_we_n", 32'(we_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_strobes", 32'({ce_n, we_n, oe_n}), 32'h7);
    check("arst_state", 32'(dbg_state), 32'd0);
    check("arst_addr", 32'(sram_addr), 32'd0);
    check("arst_ack", 32'(bus.o_rec_ack), 32'd0);
    check("arst_len", 32'(bus.o_length), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.i_track = 1'b1;
    tick();
    check("arst_len_t1", 32'(bus.o_length), 32'd0);
    check("arst_full_t1", 32'(bus.o_full), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
